buffer_scheduler: RTL and testbench

BUFFER_SCHEDULER -- requirements
Module: buffer_scheduler

---
 rtl/buffer_scheduler.sv | 150 +++++++++++++++
 tb/tb_buffer_scheduler.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/buffer_scheduler.sv
// Four depth-6 FIFOs drained one entry per scheduling tick. The buffer to drain
// is chosen by occupancy under a latency/reliability mode picked from weighted scores.
module buffer_scheduler #(
  parameter int TICK_DIV = 75000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_valid,
  input  logic [1:0] push_sel,
  input  logic [1:0] push_data,
  output logic       push_ready,
  output logic [1:0] disp,
  output logic       disp_valid,
  output logic       mode,
  output logic [2:0] occ1,
  output logic [2:0] occ2,
  output logic [2:0] occ3,
  output logic [2:0] occ4,
  output logic [5:0] rea_sc,
  output logic [5:0] lat_sc,
  output logic [7:0] drop_cnt
);

  localparam int                CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [2:0]        DEPTH     = 3'd6;

  function automatic logic [2:0] ptr_inc(input logic [2:0] p);
    return (p == 3'd5) ? 3'd0 : p + 3'd1;
  endfunction

  function automatic logic [5:0] weigh(input logic [2:0] occ, input logic [2:0] w);
    return 6'(occ) * 6'(w);
  endfunction

  logic [1:0]       mem_r    [4][6];
  logic [2:0]       occ_r    [4];
  logic [2:0]       rd_ptr_r [4];
  logic [2:0]       wr_ptr_r [4];
  logic [CNT_W-1:0] tick_cnt_r;
  logic             mode_r;
  logic             disp_valid_r;
  logic [1:0]       disp_r;
  logic [7:0]       drop_cnt_r;

  logic             tick_s;
  logic             mode_next_s;
  logic             take_s;
  logic             any_s;
  logic [2:0]       best_s;
  logic [1:0]       sel_s;
  logic [3:0]       push_acc_s;
  logic [3:0]       pop_s;
  logic [1:0]       head_s;

  assign tick_s      = (tick_cnt_r == TICK_LAST);
  assign push_ready  = (occ_r[push_sel] < DEPTH);
  assign rea_sc      = weigh(occ_r[0], 3'd1) + weigh(occ_r[1], 3'd2)
                     + weigh(occ_r[2], 3'd3) + weigh(occ_r[3], 3'd4);
  assign lat_sc      = weigh(occ_r[0], 3'd4) + weigh(occ_r[1], 3'd3)
                     + weigh(occ_r[2], 3'd2) + weigh(occ_r[3], 3'd1);
  assign mode_next_s = (rea_sc < lat_sc) ? 1'b0 : 1'b1;
  assign any_s       = (best_s != 3'd0);
  assign head_s      = mem_r[sel_s][rd_ptr_r[sel_s]];

  // Fullest buffer wins; equal occupancy goes low index in latency mode, high in reliability mode.
  always_comb begin
    best_s = 3'd0;
    sel_s  = 2'd0;
    take_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      take_s = mode_next_s ? (occ_r[i] >= best_s) : (occ_r[i] > best_s);
      best_s = take_s ? occ_r[i] : best_s;
      sel_s  = take_s ? 2'(i) : sel_s;
    end
  end

  // Per-buffer accepted push and tick pop strobes, both from pre-edge occupancy.
  always_comb begin
    push_acc_s = 4'b0000;
    pop_s      = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      push_acc_s[i] = push_valid && (push_sel == 2'(i)) && (occ_r[i] < DEPTH);
      pop_s[i]      = tick_s && any_s && (sel_s == 2'(i));
    end
  end

  // Tick counter, mode, display and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_r   <= '0;
      mode_r       <= 1'b1;
      disp_r       <= 2'b00;
      disp_valid_r <= 1'b0;
      drop_cnt_r   <= 8'd0;
    end else begin
      tick_cnt_r   <= tick_s ? '0 : tick_cnt_r + CNT_W'(1);
      disp_valid_r <= tick_s && any_s;
      if (tick_s) begin
        mode_r <= mode_next_s;
      end
      if (tick_s && any_s) begin
        disp_r <= head_s;
      end
      if (push_valid && !push_ready && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        occ_r[i]    <= 3'd0;
        rd_ptr_r[i] <= 3'd0;
        wr_ptr_r[i] <= 3'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push_acc_s[i]) begin
          wr_ptr_r[i] <= ptr_inc(wr_ptr_r[i]);
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= ptr_inc(rd_ptr_r[i]);
        end
        occ_r[i] <= occ_r[i] + 3'(push_acc_s[i]) - 3'(pop_s[i]);
      end
    end
  end

  // Entry storage; contents past the occupancy window are never read, so no reset is needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push_acc_s[i]) begin
        mem_r[i][wr_ptr_r[i]] <= push_data;
      end
    end
  end

  assign disp       = disp_r;
  assign disp_valid = disp_valid_r;
  assign mode       = mode_r;
  assign drop_cnt   = drop_cnt_r;
  assign occ1       = occ_r[0];
  assign occ2       = occ_r[1];
  assign occ3       = occ_r[2];
  assign occ4       = occ_r[3];

endmodule

// File: tb/tb_buffer_scheduler.sv
// Directed bench for buffer_scheduler with TICK_DIV=4: expected pops are queued
// at each tick and a negedge monitor checks them against disp/mode on disp_valid.
module tb_buffer_scheduler;

  logic       clk;
  logic       rst;
  logic       push_valid;
  logic [1:0] push_sel;
  logic [1:0] push_data;
  logic       push_ready;
  logic [1:0] disp;
  logic       disp_valid;
  logic       mode;
  logic [2:0] occ1, occ2, occ3, occ4;
  logic [5:0] rea_sc, lat_sc;
  logic [7:0] drop_cnt;

  buffer_scheduler #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_sel(push_sel),
    .push_data(push_data), .push_ready(push_ready), .disp(disp),
    .disp_valid(disp_valid), .mode(mode), .occ1(occ1), .occ2(occ2),
    .occ3(occ3), .occ4(occ4), .rea_sc(rea_sc), .lat_sc(lat_sc),
    .drop_cnt(drop_cnt)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         phase    = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_e;

  // Drain sequence after the buffer2 fill: {valid, mode, disp}
  logic [3:0] drain_tbl [11] = '{4'b1101, 4'b1110, 4'b1100, 4'b1111, 4'b1100,
                                 4'b1101, 4'b1100, 4'b1110, 4'b1100, 4'b1011,
                                 4'b0100};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // phase mirrors the DUT tick counter value for the cycle after the edge
  task automatic cycle();
    @(posedge clk);
    phase = rst ? 0 : ((phase == 3) ? 0 : phase + 1);
    #1;
    rst        = 1'b0;
    push_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
  endtask

  task automatic set_push(input logic [1:0] sel, input logic [1:0] data);
    push_valid = 1'b1;
    push_sel   = sel;
    push_data  = data;
  endtask

  task automatic push_one(input logic [1:0] sel, input logic [1:0] data);
    set_push(sel, data);
    cycle();
  endtask

  task automatic to_tick();
    while (phase != 3) cycle();
  endtask

  task automatic tick_expect(input logic has, input logic [1:0] d, input logic m);
    if (has) exp_q.push_back({m, d});
    cycle();
  endtask

  always @(negedge clk) begin
    if (disp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_disp_valid", int'(disp_valid), 0);
      end else begin
        exp_e = exp_q.pop_front();
        check("pop_disp", int'(disp), int'(exp_e[1:0]));
        check("pop_mode", int'(mode), int'(exp_e[2]));
      end
    end
  end

  initial begin
    rst = 1'b0; push_valid = 1'b0; push_sel = 2'd0; push_data = 2'd0;
    do_reset();

    // Reset state, then three idle ticks
    do_reset();
    check("rst_occ1", occ1, 0); check("rst_occ2", occ2, 0);
    check("rst_occ3", occ3, 0); check("rst_occ4", occ4, 0);
    check("rst_rea", rea_sc, 0); check("rst_lat", lat_sc, 0);
    check("rst_mode", mode, 1); check("rst_drop", drop_cnt, 0);
    check("rst_disp", disp, 0); check("rst_dv", disp_valid, 0);
    repeat (12) cycle();
    check("idle_mode", mode, 1);
    check("idle_occ1", occ1, 0);

    // Latency mode pop from buffer1
    do_reset();
    push_one(2'd0, 2'b10); push_one(2'd0, 2'b01); push_one(2'd3, 2'b11);
    check("t2_rea", rea_sc, 6); check("t2_lat", lat_sc, 9);
    tick_expect(1'b1, 2'b10, 1'b0);
    check("t2_dv", disp_valid, 1); check("t2_mode", mode, 0);
    check("t2_occ1", occ1, 1); check("t2_occ4", occ4, 1);
    cycle();
    check("t2_dv_pulse", disp_valid, 0);

    // Reliability mode tie goes to buffer4
    do_reset();
    push_one(2'd2, 2'b01); push_one(2'd3, 2'b11); cycle();
    check("t3_rea", rea_sc, 7); check("t3_lat", lat_sc, 3);
    tick_expect(1'b1, 2'b11, 1'b1);
    check("t3_occ4", occ4, 0); check("t3_occ3", occ3, 1); check("t3_mode", mode, 1);

    // Push and pop of the same buffer on a tick
    do_reset();
    push_one(2'd0, 2'b01); push_one(2'd0, 2'b11); push_one(2'd0, 2'b01);
    set_push(2'd0, 2'b10);
    tick_expect(1'b1, 2'b01, 1'b0);
    check("t5_occ1", occ1, 3);
    to_tick(); tick_expect(1'b1, 2'b11, 1'b0);
    to_tick(); tick_expect(1'b1, 2'b01, 1'b0);
    to_tick(); tick_expect(1'b1, 2'b10, 1'b0);
    check("t5_occ1_empty", occ1, 0);

    // Buffer2 overflow while buffer4 absorbs the ticks
    do_reset();
    push_one(2'd3, 2'b00); push_one(2'd3, 2'b00); push_one(2'd3, 2'b00);
    set_push(2'd3, 2'b00); tick_expect(1'b1, 2'b00, 1'b1);
    push_one(2'd3, 2'b00); push_one(2'd3, 2'b00); push_one(2'd3, 2'b00);
    set_push(2'd1, 2'b01); tick_expect(1'b1, 2'b00, 1'b1);
    push_one(2'd1, 2'b10); push_one(2'd1, 2'b11); push_one(2'd1, 2'b01);
    set_push(2'd1, 2'b10); tick_expect(1'b1, 2'b00, 1'b1);
    set_push(2'd1, 2'b11); #1;
    check("t4_ready_5", push_ready, 1);
    cycle();
    set_push(2'd1, 2'b00); #1;
    check("t4_ready_full", push_ready, 0);
    cycle();
    check("t4_occ2", occ2, 6); check("t4_drop", drop_cnt, 1); check("t4_occ4", occ4, 4);
    for (int k = 0; k < 11; k++) begin
      to_tick();
      tick_expect(drain_tbl[k][3], drain_tbl[k][1:0], drain_tbl[k][2]);
    end
    check("t4_mode_end", mode, 1); check("t4_occ2_end", occ2, 0); check("t4_occ4_end", occ4, 0);

    // Reset mid-period discards contents and restarts the tick counter
    push_one(2'd0, 2'b01); push_one(2'd2, 2'b10); push_one(2'd0, 2'b11);
    tick_expect(1'b1, 2'b01, 1'b0);
    push_one(2'd1, 2'b11);
    set_push(2'd0, 2'b10);
    do_reset();
    check("t6_occ1", occ1, 0); check("t6_occ2", occ2, 0);
    check("t6_occ3", occ3, 0); check("t6_occ4", occ4, 0);
    check("t6_drop", drop_cnt, 0); check("t6_disp", disp, 0);
    check("t6_mode", mode, 1); check("t6_dv", disp_valid, 0);
    push_one(2'd2, 2'b01); cycle(); cycle();
    check("t6_dv_before", disp_valid, 0); check("t6_occ3", occ3, 1);
    tick_expect(1'b1, 2'b01, 1'b1);
    check("t6_dv_at_tick", disp_valid, 1);
    cycle();

    check("pending_pops", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
